// File: rtl/chess_pkg.sv
// Shared chess definitions: piece/colour encoding, board-writer FSM states,
// the reset board image and the pawn promotion rule.
package chess_pkg;

  typedef logic [3:0] piece_t;
  typedef logic [5:0] square_t;

  localparam int COLOR_BIT = 3;

  typedef enum logic {
    C_WHITE = 1'b0,
    C_BLACK = 1'b1
  } color_e;

  typedef enum logic [2:0] {
    P_EMPTY  = 3'd0,
    P_PAWN   = 3'd1,
    P_KNIGHT = 3'd2,
    P_BISHOP = 3'd3,
    P_ROOK   = 3'd4,
    P_QUEEN  = 3'd5,
    P_KING   = 3'd6
  } ptype_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_COMMIT,
    S_REJECT,
    S_DONE
  } state_e;

  // Square n lives at bits [4n+3:4n]; rank 8 is the top word, rank 1 the bottom.
  localparam logic [255:0] INIT_BOARD = {
    32'hCABEDBAC, 32'h99999999,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h11111111, 32'h42365324
  };

  function automatic piece_t promote(input piece_t p, input square_t to, input logic en);
    piece_t r;
    r = p;
    if (en && (p[2:0] == P_PAWN)) begin
      if ((p[COLOR_BIT] == C_WHITE) && (to[5:3] == 3'd7)) begin
        r = {C_WHITE, P_QUEEN};
      end else if ((p[COLOR_BIT] == C_BLACK) && (to[5:3] == 3'd0)) begin
        r = {C_BLACK, P_QUEEN};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/board_writer_if.sv
// Move request handshake plus board/game status bus between a move source
// and the board writer.
interface board_writer_if;
  import chess_pkg::*;

  logic         move_valid;
  square_t      move_from;
  square_t      move_to;
  logic         move_ready;
  logic         done;
  logic         accepted;
  piece_t       captured;
  logic [255:0] board;
  logic         turn;
  logic         game_over;

  modport master (
    output move_valid, move_from, move_to,
    input  move_ready, done, accepted, captured, board, turn, game_over
  );

  modport slave (
    input  move_valid, move_from, move_to,
    output move_ready, done, accepted, captured, board, turn, game_over
  );
endinterface

// File: rtl/board_writer_square_mux.sv
// 64:1 read mux selecting one 4-bit square nibble out of the packed board.
module square_mux
  import chess_pkg::*;
(
  input  logic [255:0] board_i,
  input  square_t      sel_i,
  output piece_t       sq_o
);

  piece_t squares [64];

  always_comb begin
    for (int i = 0; i < 64; i++) begin
      squares[i] = board_i[4*i +: 4];
    end
  end

  assign sq_o = squares[sel_i];

endmodule

// File: rtl/board_writer.sv
// Board register with a fixed-latency move writer: fetch both squares,
// screen the move, commit or reject, then pulse done.
module board_writer
  import chess_pkg::*;
#(
  parameter bit AUTO_PROMOTE = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  board_writer_if.slave bus
);

  state_e       state_q, state_d;
  square_t      from_q, from_d, to_q, to_d;
  piece_t       src_q, src_d, dst_q, dst_d;
  piece_t       src_rd, dst_rd;
  piece_t       captured_q, captured_d;
  logic [255:0] board_q, board_d;
  logic         acc_q, acc_d;
  logic         turn_q, turn_d;
  logic         over_q, over_d;
  logic         legal;

  square_mux u_src_mux (
    .board_i (board_q),
    .sel_i   (from_q),
    .sq_o    (src_rd)
  );

  square_mux u_dst_mux (
    .board_i (board_q),
    .sel_i   (to_q),
    .sq_o    (dst_rd)
  );

  // Only ownership and self-capture are screened; piece movement is not.
  always_comb begin
    legal = (src_q[2:0] != P_EMPTY)
         && (src_q[COLOR_BIT] == turn_q)
         && (from_q != to_q)
         && !((dst_q[2:0] != P_EMPTY) && (dst_q[COLOR_BIT] == src_q[COLOR_BIT]));
  end

  always_comb begin
    state_d    = state_q;
    from_d     = from_q;
    to_d       = to_q;
    src_d      = src_q;
    dst_d      = dst_q;
    captured_d = captured_q;
    board_d    = board_q;
    acc_d      = acc_q;
    turn_d     = turn_q;
    over_d     = over_q;

    case (state_q)
      S_IDLE: begin
        if (bus.move_valid && !over_q) begin
          from_d  = bus.move_from;
          to_d    = bus.move_to;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        src_d   = src_rd;
        dst_d   = dst_rd;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        acc_d   = legal;
        state_d = legal ? S_COMMIT : S_REJECT;
      end
      S_COMMIT: begin
        board_d[{to_q, 2'b00} +: 4]   = promote(src_q, to_q, AUTO_PROMOTE);
        board_d[{from_q, 2'b00} +: 4] = '0;
        captured_d                    = dst_q;
        state_d                       = S_DONE;
      end
      S_REJECT: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (acc_q) begin
          turn_d = ~turn_q;
          if (captured_q[2:0] == P_KING) begin
            over_d = 1'b1;
          end
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      board_q    <= INIT_BOARD;
      captured_q <= '0;
      acc_q      <= 1'b0;
      turn_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      captured_q <= captured_d;
      acc_q      <= acc_d;
      turn_q     <= turn_d;
      over_q     <= over_d;
    end
  end

  // Request latches carry no reset; they are always rewritten before use.
  always_ff @(posedge clk) begin
    from_q <= from_d;
    to_q   <= to_d;
    src_q  <= src_d;
    dst_q  <= dst_d;
  end

  assign bus.move_ready = (state_q == S_IDLE) && !over_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.accepted   = acc_q;
  assign bus.captured   = captured_q;
  assign bus.board      = board_q;
  assign bus.turn       = turn_q;
  assign bus.game_over  = over_q;

endmodule

// File: tb/tb_board_writer.sv
// Scoreboard bench for board_writer: a square-array chess model predicts each
// move's outcome, and a monitor checks it whenever done pulses.
module tb_board_writer;
  import chess_pkg::*;

  logic clk = 1'b0;
  logic reset;

  board_writer_if bus ();

  board_writer #(.AUTO_PROMOTE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         acc;
    logic [3:0]   cap;
    logic [255:0] brd;
    logic         trn;
    logic         ovr;
    int           cyc0;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [3:0] mb [64];
  logic       mturn;
  logic       mover;
  logic [3:0] mcap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    int back [8];
    back = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int i = 0; i < 64; i++) mb[i] = 4'h0;
    for (int f = 0; f < 8; f++) begin
      mb[f]      = 4'(back[f]);
      mb[8 + f]  = 4'h1;
      mb[48 + f] = 4'h9;
      mb[56 + f] = 4'(back[f] + 8);
    end
    mturn = 1'b0;
    mover = 1'b0;
    mcap  = 4'h0;
  endfunction

  function automatic logic [255:0] pack();
    logic [255:0] b;
    for (int i = 0; i < 64; i++) b[4*i +: 4] = mb[i];
    return b;
  endfunction

  function automatic exp_t model_move(input int f, input int t);
    exp_t       e;
    logic [3:0] s, d, placed;
    logic       ok;
    s  = mb[f];
    d  = mb[t];
    ok = (s != 4'h0) && (s[3] == mturn) && (f != t) && !((d != 4'h0) && (d[3] == s[3]));
    if (ok) begin
      placed = s;
      if (s == 4'h1 && t >= 56) placed = 4'h5;
      if (s == 4'h9 && t < 8)   placed = 4'hD;
      mb[t] = placed;
      mb[f] = 4'h0;
      mcap  = d;
      mturn = ~mturn;
      if (d == 4'h6 || d == 4'hE) mover = 1'b1;
    end
    e.acc = ok;
    e.cap = mcap;
    e.brd = pack();
    e.trn = mturn;
    e.ovr = mover;
    e.cyc0 = 0;
    return e;
  endfunction

  // Issue one move at a negedge, optionally keep junk requests on the bus
  // while busy, then wait for the monitor to retire it.
  task automatic do_move(input int f, input int t, input bit hold);
    exp_t e;
    int   n;
    n = 0;
    while (bus.move_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.move_ready !== 1'b1) begin
      chk("ready_timeout", 256'(bus.move_ready), 256'd1);
      return;
    end
    bus.move_valid = 1'b1;
    bus.move_from  = 6'(f);
    bus.move_to    = 6'(t);
    e      = model_move(f, t);
    e.cyc0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        bus.move_from = 6'($urandom_range(0, 63));
        bus.move_to   = 6'($urandom_range(0, 63));
        @(negedge clk);
      end
    end
    bus.move_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 256'(sb.size()), 256'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.move_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_done", 256'(bus.done), 256'd0);
    chk("rst_board", bus.board, pack());
    chk("rst_turn", 256'(bus.turn), 256'd0);
    chk("rst_over", 256'(bus.game_over), 256'd0);
    chk("rst_captured", 256'(bus.captured), 256'd0);
    chk("rst_accepted", 256'(bus.accepted), 256'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 256'(bus.move_ready), 256'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 required no pending move (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("latency", 256'(cyc - e.cyc0), 256'd4);
          chk("accepted", 256'(bus.accepted), 256'(e.acc));
          chk("captured", 256'(bus.captured), 256'(e.cap));
          chk("board", bus.board, e.brd);
          @(negedge clk);
          chk("done_width", 256'(bus.done), 256'd0);
          chk("turn", 256'(bus.turn), 256'(e.trn));
          chk("game_over", 256'(bus.game_over), 256'(e.ovr));
          chk("ready_after", 256'(bus.move_ready), 256'(!e.ovr));
        end
      end
    end
  end

  initial begin : stimulus
    int cand [$];
    int f, t;
    reset          = 1'b1;
    bus.move_valid = 1'b0;
    bus.move_from  = '0;
    bus.move_to    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_lo", 256'(bus.board[31:0]), 256'h42365324);
    chk("init_rank2", 256'(bus.board[63:32]), 256'h11111111);
    chk("init_rank8", 256'(bus.board[255:224]), 256'hCABEDBAC);
    reset = 1'b0;
    @(negedge clk);
    chk("init_turn", 256'(bus.turn), 256'd0);
    chk("init_ready", 256'(bus.move_ready), 256'd1);

    // Plain pawn push
    do_move(12, 28, 1'b0);
    chk("sq28_pawn", 256'(bus.board[115:112]), 256'h1);
    chk("sq12_empty", 256'(bus.board[51:48]), 256'h0);
    chk("turn_black", 256'(bus.turn), 256'd1);

    // Rejections: wrong colour, self-capture, null move, empty source
    do_reset();
    do_move(52, 36, 1'b0);
    do_move(0, 8, 1'b0);
    do_move(12, 12, 1'b0);
    do_move(20, 28, 1'b0);
    chk("rej_turn", 256'(bus.turn), 256'd0);
    chk("rej_board", bus.board, 256'(INIT_BOARD));

    // King capture ends the game; further requests are ignored
    do_move(3, 60, 1'b1);
    chk("kcap_captured", 256'(bus.captured), 256'hE);
    chk("kcap_over", 256'(bus.game_over), 256'd1);
    bus.move_valid = 1'b1;
    bus.move_from  = 6'd12;
    bus.move_to    = 6'd28;
    repeat (8) @(negedge clk);
    bus.move_valid = 1'b0;
    chk("over_ready", 256'(bus.move_ready), 256'd0);
    chk("over_board", bus.board, pack());

    // Promotion for both colours
    do_reset();
    do_move(8, 56, 1'b0);
    chk("promo_white", 256'(bus.board[227:224]), 256'h5);
    chk("promo_cap", 256'(bus.captured), 256'hC);
    do_move(48, 0, 1'b1);
    chk("promo_black", 256'(bus.board[3:0]), 256'hD);

    // Reset while the move sits in CHECK
    @(negedge clk);
    bus.move_valid = 1'b1;
    bus.move_from  = 6'd12;
    bus.move_to    = 6'd28;
    @(negedge clk);
    bus.move_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_board", bus.board, pack());
    chk("midrst_ready", 256'(bus.move_ready), 256'd1);
    chk("midrst_turn", 256'(bus.turn), 256'd0);

    // Randomized play
    for (int it = 0; it < 120; it++) begin
      if (mover) do_reset();
      cand.delete();
      for (int s = 0; s < 64; s++) begin
        if (mb[s] != 4'h0 && mb[s][3] == mturn) cand.push_back(s);
      end
      if (($urandom % 4) != 0 && cand.size() != 0) begin
        f = cand[$urandom_range(0, cand.size() - 1)];
      end else begin
        f = $urandom_range(0, 63);
      end
      t = $urandom_range(0, 63);
      do_move(f, t, 1'($urandom % 2));
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 256'(sb.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_writer.md
BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 SHALL have parameter AUTO_PROMOTE, default 1, meaning a pawn reaching the far rank becomes a queen; 0 keeps it a pawn.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port move_valid  input  1  move request present.
REQ-005 SHALL have port move_from  input  6  source square, index = rank*8+file (0 = a1, 63 = h8).
REQ-006 SHALL have port move_to  input  6  destination square, same indexing.
REQ-007 SHALL have port move_ready  output  1  block can accept a request this cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse, request finished.
REQ-009 SHALL have port accepted  output  1  qualified by done: 1 = committed, 0 = rejected.
REQ-010 SHALL have port captured  output  4  piece code removed from move_to by the last committed move, else 0.
REQ-011 SHALL have port board  output  256  registered board; square n at bits [4n+3:4n].
REQ-012 SHALL have port turn  output  1  side to move: 0 = white, 1 = black.
REQ-013 SHALL have port game_over  output  1  sticky; a king was captured.

Function
REQ-014 SHALL encode pieces as bit3 = colour (0 white, 1 black), bits2:0 = 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king.
REQ-015 SHALL accept a request on a rising edge where move_valid and move_ready are both 1, latching move_from and move_to.
REQ-016 SHALL assert move_ready only in IDLE with game_over = 0.
REQ-017 SHALL sequence IDLE -> FETCH -> CHECK -> COMMIT or REJECT -> DONE -> IDLE, one cycle per state.
REQ-018 SHALL, in FETCH, latch the source and destination nibbles.
REQ-019 SHALL reject in CHECK if any of these hold: source empty; source colour != turn; move_from == move_to; destination non-empty with the source colour.
REQ-020 SHALL perform no path or piece-movement legality checking.
REQ-021 SHALL, in COMMIT, write the source piece to move_to and write 0 to move_from.
REQ-022 SHALL, when AUTO_PROMOTE = 1 in COMMIT, write 4'h5 for a white pawn landing on squares 56-63 and 4'hD for a black pawn landing on squares 0-7.
REQ-023 SHALL, in COMMIT, load captured with the old destination nibble.
REQ-024 SHALL, in REJECT, leave board, turn and captured unchanged.
REQ-025 SHALL, in DONE, hold done = 1 for exactly one cycle, with accepted valid in that cycle.
REQ-026 SHALL make the committed board visible in the DONE cycle.
REQ-027 SHALL toggle turn in the DONE cycle of an accepted move.
REQ-028 SHALL fix latency: accept edge at cycle 0, done high during cycle 4, move_ready high again in cycle 5.
REQ-029 SHALL set game_over in DONE when captured bits2:0 = 6, and hold it until reset.
REQ-030 SHALL ignore move_valid while move_ready = 0; requests are not queued.

Reset
REQ-031 SHALL, while reset = 1, asynchronously force: state IDLE; board = initial position; turn = 0; done, accepted and game_over = 0; captured = 0.
REQ-032 SHALL set the initial position as: squares 0-7 = 4,2,3,5,6,3,2,4; squares 8-15 = 1; squares 48-55 = 9; squares 56-63 = C,A,B,D,E,B,A,C; all others 0.
REQ-033 SHALL, on reset asserted mid-operation, produce no done pulse and discard the in-flight move.

Structure
REQ-034 SHALL place piece codes, colour bit, state encoding and the INIT_BOARD 256-bit constant in shared package chess_pkg.
REQ-035 SHALL use one sub-module, square_mux, a 64:1 4-bit read mux shared by the source and destination fetch.

Verification
REQ-036 SHALL cover reset: -> board[31:0] = 32'h42365324, board[63:32] = 32'h11111111, board[255:224] = 32'hCABEDBAC, turn = 0, move_ready = 1.
REQ-037 SHALL cover from = 12, to = 28: -> done in cycle 4, accepted = 1, square 28 = 1, square 12 = 0, captured = 0, turn = 1.
REQ-038 SHALL cover, with turn = 0, from = 52, to = 36: -> accepted = 0, board unchanged, turn = 0. Then from = 0, to = 8: -> accepted = 0.
REQ-039 SHALL cover, after reset, from = 3, to = 60: -> accepted = 1, captured = 4'hE, game_over = 1, move_ready = 0 until reset.
REQ-040 SHALL cover promotion: white pawn at 8 moved to 56 -> square 56 = 4'h5, captured = 4'hC.
REQ-041 SHALL cover reset pulsed during CHECK: -> no done pulse, board = initial position, move_ready = 1 after release.
